// File: rtl/fetch_pkg.sv
// Shared fetch-queue sizing constants and skip-state encoding.
// Pure definitions; no latency, no backpressure.
package fetch_pkg;
    localparam int FQ_DEPTH     = 32;
    localparam int FQ_WIN       = 16;
    localparam int FQ_WR_BYTES  = 8;
    localparam int MAX_INSN_LEN = 15;

    typedef enum logic {
        RUN  = 1'b0,
        SKIP = 1'b1
    } fq_state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: redirect, 8-byte write handshake, decode window and consume.
// Master drives writes/consumes/flush; slave (the queue) returns ready, window and error.
interface fetch_queue_if;
    logic         flush;
    logic [2:0]   flush_offset;
    logic         wr_valid;
    logic [63:0]  wr_data;
    logic         wr_ready;
    logic [127:0] rd_bytes;
    logic [4:0]   rd_count;
    logic         consume_valid;
    logic [3:0]   consume_len;
    logic         err_overconsume;

    modport master (
        output flush, flush_offset, wr_valid, wr_data, consume_valid, consume_len,
        input  wr_ready, rd_bytes, rd_count, err_overconsume
    );

    modport slave (
        input  flush, flush_offset, wr_valid, wr_data, consume_valid, consume_len,
        output wr_ready, rd_bytes, rd_count, err_overconsume
    );
endinterface

// File: rtl/fq_window_rotator.sv
// Rotates 32-byte circular storage to a 16-byte window starting at rd_ptr.
// Combinational; bytes at index >= count read as zero so stale storage never leaks.
module fq_window_rotator
    import fetch_pkg::*;
(
    input  logic [8*FQ_DEPTH-1:0] storage,
    input  logic [4:0]            rd_ptr,
    input  logic [4:0]            count,
    output logic [8*FQ_WIN-1:0]   window
);
    for (genvar g = 0; g < FQ_WIN; g++) begin : g_win
        logic [4:0] idx;
        assign idx = rd_ptr + 5'(g);
        assign window[8*g +: 8] = (5'(g) < count) ? storage[8*idx +: 8] : 8'h00;
    end
endmodule

// File: rtl/fetch_queue.sv
// 32-byte instruction fetch queue with redirect skip; 1-cycle write-to-window latency,
// or same-cycle on an empty queue when FETCH_QUEUE_BYPASS_EN is defined. wr_ready = fill <= 24.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset_b,
    fetch_queue_if.slave  bus
);
    logic [8*FQ_DEPTH-1:0] storage;
    logic [4:0]            rd_ptr;
    logic [4:0]            wr_ptr;
    logic [5:0]            fill;
    logic [2:0]            skip_off;
    logic                  err;
    fq_state_t             state;
    fq_state_t             state_nxt;
    logic [2:0]            drop;
    logic [3:0]            kept;
    logic                  wr_acc;
    logic [4:0]            win_count;
    logic [8*FQ_WIN-1:0]   win_bytes;
    logic [4:0]            rd_count;
    logic [127:0]          rd_bytes;
    logic                  cons_ok;
    logic                  cons_over;

    assign bus.wr_ready = (fill <= 6'(FQ_DEPTH - FQ_WR_BYTES));
    assign wr_acc       = bus.wr_valid & bus.wr_ready & ~bus.flush;
    assign kept         = 4'(FQ_WR_BYTES) - {1'b0, drop};
    assign win_count    = (fill >= 6'(FQ_WIN)) ? 5'(FQ_WIN) : fill[4:0];

    fq_window_rotator u_rot (
        .storage (storage),
        .rd_ptr  (rd_ptr),
        .count   (win_count),
        .window  (win_bytes)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: show the freshly accepted bytes directly; shifting zero-fills the tail.
    logic bypass;
    assign bypass   = (fill == 6'd0) & wr_acc;
    assign rd_bytes = bypass ? {64'h0, bus.wr_data >> {drop, 3'b000}} : win_bytes;
    assign rd_count = bypass ? {1'b0, kept} : win_count;
`else
    assign rd_bytes = win_bytes;
    assign rd_count = win_count;
`endif

    assign bus.rd_bytes        = rd_bytes;
    assign bus.rd_count        = rd_count;
    assign bus.err_overconsume = err;

    assign cons_ok   = bus.consume_valid & ~bus.flush & (bus.consume_len != 4'd0)
                     & ({1'b0, bus.consume_len} <= rd_count);
    assign cons_over = bus.consume_valid & ~bus.flush & ({1'b0, bus.consume_len} > rd_count);

    always_ff @(posedge clk) begin
        if (!reset_b) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush)
            state_nxt = (bus.flush_offset != 3'd0) ? SKIP : RUN;
        else if (state == SKIP && wr_acc)
            state_nxt = RUN;
    end

    always_comb begin
        drop = 3'd0;
        if (state == SKIP) drop = skip_off;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < FQ_WR_BYTES; i++) begin
                if (3'(i) >= drop)
                    storage[8*5'(wr_ptr + 5'(i) - 5'(drop)) +: 8] <= bus.wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rd_ptr   <= 5'd0;
            wr_ptr   <= 5'd0;
            fill     <= 6'd0;
            skip_off <= 3'd0;
            err      <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr   <= 5'd0;
            wr_ptr   <= 5'd0;
            fill     <= 6'd0;
            skip_off <= bus.flush_offset;
        end else begin
            if (wr_acc)    wr_ptr <= wr_ptr + 5'(kept);
            if (cons_ok)   rd_ptr <= rd_ptr + 5'(bus.consume_len);
            fill <= fill + (wr_acc ? 6'(kept) : 6'd0) - (cons_ok ? 6'(bus.consume_len) : 6'd0);
            if (cons_over) err <= 1'b1;
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: reset_b  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL provide: flush  input  1  branch redirect; discard all queued bytes.
REQ-004 SHALL provide: flush_offset  input  3  byte offset of redirect target within next 8-byte write.
REQ-005 SHALL provide: wr_valid  input  1  fetch line chunk offered.
REQ-006 SHALL provide: wr_data  input  64  8 instruction bytes, lowest address in [7:0].
REQ-007 SHALL provide: wr_ready  output  1  queue can accept 8 bytes.
REQ-008 SHALL provide: rd_bytes  output  128  decode window, oldest byte at [7:0], byte i at [8i+7:8i]; bytes 0/1 feed opcode and ModRM detection.
REQ-009 SHALL provide: rd_count  output  5  valid bytes in window, 0..16.
REQ-010 SHALL provide: consume_valid  input  1  decoder retires an instruction.
REQ-011 SHALL provide: consume_len  input  4  instruction length in bytes, legal 1..15.
REQ-012 SHALL provide: err_overconsume  output  1  sticky illegal-consume flag.

Function
REQ-013 SHALL store 32 bytes circularly with 5-bit rd_ptr/wr_ptr wrapping mod 32 and 6-bit fill 0..32.
REQ-014 SHALL drive wr_ready = (fill <= 24) from registered fill only, independent of same-cycle consume.
REQ-015 SHALL accept a write when wr_valid & wr_ready & !flush, appending bytes at wr_ptr, advancing wr_ptr and fill by bytes kept.
REQ-016 SHALL implement states RUN and SKIP: flush with flush_offset != 0 -> SKIP, flush with 0 -> RUN; in SKIP first accepted write drops its lowest flush_offset bytes, keeps 8-flush_offset, -> RUN.
REQ-017 SHALL drive rd_bytes as bytes rd_ptr..rd_ptr+15 mod 32, bytes at index >= rd_count forced to 0x00; rd_count = min(fill,16).
REQ-018 SHALL make an accepted byte visible in rd_bytes the cycle after acceptance (1-cycle latency).
REQ-019 SHALL accept consume when consume_valid & 1 <= consume_len <= rd_count & !flush: rd_ptr += len, fill -= len.
REQ-020 SHALL treat consume_len = 0 as no-op without error.
REQ-021 SHALL ignore consume with consume_len > rd_count (no pointer/fill change) and set err_overconsume next cycle, held until reset.
REQ-022 SHALL on simultaneous write and consume update fill = fill + kept - len, consume checked against pre-write rd_count.
REQ-023 SHALL on flush set next cycle fill=0, rd_ptr=wr_ptr=0, captured offset per REQ-016; flush overrides same-cycle write and consume (both dropped); err_overconsume unaffected.

Reset
REQ-024 SHALL on reset_b=0 at clk edge set fill=0, pointers=0, state RUN, skip offset 0, err_overconsume=0; after reset rd_count=0, wr_ready=1.
REQ-025 SHALL leave byte storage unreset; masking per REQ-017 hides stale data.
REQ-026 SHALL give reset priority over flush, write and consume.

Configuration
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when fill==0 and a write is accepted, present kept bytes in rd_bytes/rd_count same cycle and permit consume of them that cycle.
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, keep strict 1-cycle latency per REQ-018 with no combinational wr_data-to-rd_bytes path.

Structure
REQ-029 SHALL place FQ_DEPTH=32, FQ_WIN=16, FQ_WR_BYTES=8, MAX_INSN_LEN=15 and RUN/SKIP state encoding in shared package fetch_pkg.
REQ-030 SHALL implement window rotate-and-mask as sub-module fq_window_rotator (32-byte storage, rd_ptr, count -> 16-byte window).

Verification
REQ-031 SHALL cover: reset, write bytes 00..07, 08..0F, 10..17, 18..1F -> fill=32, wr_ready=0, rd_count=16, byte0=0x00.
REQ-032 SHALL cover: from REQ-031 consume 3 then 5 -> byte0=0x03 then 0x08, wr_ready=1 after second consume (fill=24).
REQ-033 SHALL cover: wrap -- consume to rd_ptr=28, write 20..27 -> window bytes 0x1C..0x1F then 0x20.. contiguous across index 31->0.
REQ-034 SHALL cover: flush offset=5, then write 00..07 -> rd_count=3, byte0=0x05, state RUN.
REQ-035 SHALL cover: rd_count=3, consume_len=4 -> no change, err_overconsume=1 next cycle, still 1 after flush.
REQ-036 SHALL cover: flush with wr_valid=1, consume_valid=1 same cycle -> rd_count=0 next cycle, write dropped.
